alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu.sv | 103 ++++++++++
 tb/tb_alu.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Single-cycle ALU: combinational datapath feeding one output register stage.
// Define ALU_SHIFT_EN to build the shifter (opcodes 5-7); otherwise they return 0.
module alu #(
    parameter int WIDTH    = 32,
    parameter int OP_WIDTH = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    input  logic [WIDTH-1:0]    i_a,
    input  logic [WIDTH-1:0]    i_b,
    input  logic [OP_WIDTH-1:0] i_opcode,
    output logic                o_valid,
    output logic [WIDTH-1:0]    o_result,
    output logic                o_zero,
    output logic                o_cf
);
    localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_XOR  = OP_WIDTH'(4);
`ifdef ALU_SHIFT_EN
    localparam logic [OP_WIDTH-1:0] OP_SLL  = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_SRL  = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_SRA  = OP_WIDTH'(7);
    localparam int                  SH_W    = $clog2(WIDTH);
`endif
    localparam logic [OP_WIDTH-1:0] OP_SLT  = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_SLTU = OP_WIDTH'(9);

    logic [WIDTH-1:0] res_d;
    logic             cf_d;
    logic [WIDTH:0]   ext;

`ifdef ALU_SHIFT_EN
    logic [SH_W-1:0]  sh;
    assign sh = i_b[SH_W-1:0];
`endif

    // Shifts run on a (WIDTH+1)-bit vector so the last bit shifted out
    // lands in the spare bit; for sh=0 that bit is the zero padding.
    always_comb begin
        res_d = '0;
        cf_d  = 1'b0;
        ext   = '0;
        case (i_opcode)
            OP_ADD: begin
                ext   = {1'b0, i_a} + {1'b0, i_b};
                res_d = ext[WIDTH-1:0];
                cf_d  = ext[WIDTH];
            end
            OP_SUB: begin
                ext   = {1'b0, i_a} - {1'b0, i_b};
                res_d = ext[WIDTH-1:0];
                cf_d  = ext[WIDTH];
            end
            OP_AND: res_d = i_a & i_b;
            OP_OR:  res_d = i_a | i_b;
            OP_XOR: res_d = i_a ^ i_b;
`ifdef ALU_SHIFT_EN
            OP_SLL: begin
                ext   = {1'b0, i_a} << sh;
                res_d = ext[WIDTH-1:0];
                cf_d  = ext[WIDTH];
            end
            OP_SRL: begin
                ext   = {i_a, 1'b0} >> sh;
                res_d = ext[WIDTH:1];
                cf_d  = ext[0];
            end
            OP_SRA: begin
                ext   = $unsigned($signed({i_a, 1'b0}) >>> sh);
                res_d = ext[WIDTH:1];
                cf_d  = ext[0];
            end
`endif
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, i_a < i_b};
            default: begin
                res_d = '0;
                cf_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid  <= 1'b0;
            o_result <= '0;
            o_cf     <= 1'b0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_result <= res_d;
                o_cf     <= cf_d;
            end
        end
    end

    assign o_zero = (o_result == '0);

endmodule

// File: tb/tb_alu.sv
// Directed and randomized checks of alu against a plain-arithmetic reference model.
module tb_alu;
    localparam int W = 32;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_valid = 1'b0;
    logic [W-1:0]  i_a = '0;
    logic [W-1:0]  i_b = '0;
    logic [3:0]    i_opcode = '0;
    logic          o_valid;
    logic [W-1:0]  o_result;
    logic          o_zero;
    logic          o_cf;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] exp_res;
    logic         exp_cf;

    alu #(.WIDTH(W), .OP_WIDTH(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid),
        .i_a(i_a), .i_b(i_b), .i_opcode(i_opcode),
        .o_valid(o_valid), .o_result(o_result), .o_zero(o_zero), .o_cf(o_cf)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: results from the opcode definitions using wide integer arithmetic.
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic c);
        longint unsigned s;
        int sh;
        sh = int'(b % W);
        r = '0;
        c = 1'b0;
        case (op)
            4'd0: begin s = longint'(a) + longint'(b); r = s[W-1:0]; c = (s >= 64'h1_0000_0000); end
            4'd1: begin r = a - b; c = (a < b); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
`ifdef ALU_SHIFT_EN
            4'd5: begin r = a << sh; c = (sh == 0) ? 1'b0 : a[W - sh]; end
            4'd6: begin r = a >> sh; c = (sh == 0) ? 1'b0 : a[sh - 1]; end
            4'd7: begin r = $unsigned($signed(a) >>> sh); c = (sh == 0) ? 1'b0 : a[sh - 1]; end
`endif
            4'd8: r = (int'(a) < int'(b)) ? 1 : 0;
            4'd9: r = (a < b) ? 1 : 0;
            default: begin r = '0; c = 1'b0; end
        endcase
    endtask

    task automatic check_out(input string tag, input logic v);
        check({tag, ".result"}, o_result, exp_res);
        check({tag, ".cf"}, W'(o_cf), W'(exp_cf));
        check({tag, ".zero"}, W'(o_zero), W'(exp_res == '0));
        check({tag, ".valid"}, W'(o_valid), W'(v));
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        @(negedge i_clk);
        i_valid = 1'b1; i_opcode = op; i_a = a; i_b = b;
        model(op, a, b, exp_res, exp_cf);
        @(posedge i_clk); #1;
        check_out(tag, 1'b1);
    endtask

    task automatic check_reset_state(input string tag);
        exp_res = '0; exp_cf = 1'b0;
        check_out(tag, 1'b0);
    endtask

    initial begin
        logic [3:0] op;
        logic [W-1:0] a, b;

        // Reset state, with i_valid asserted to show nothing is captured under reset.
        i_valid = 1'b1; i_opcode = 4'd0; i_a = 32'd3; i_b = 32'd4;
        #1;
        check_reset_state("reset");
        repeat (2) @(posedge i_clk);
        #1;
        check_reset_state("reset_edges");
        @(negedge i_clk);
        i_valid = 1'b0; i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        check_reset_state("post_reset_idle");

        // Directed vectors
        run_op("add_3_4", 4'd0, 32'd3, 32'd4);
        run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1);
        run_op("sub_5_3", 4'd1, 32'd5, 32'd3);
        run_op("sub_3_5", 4'd1, 32'd3, 32'd5);
        run_op("sub_eq", 4'd1, 32'd1, 32'd1);
        run_op("and", 4'd2, 32'hF0, 32'hAA);
        run_op("or", 4'd3, 32'hF0, 32'hAA);
        run_op("xor", 4'd4, 32'hF0, 32'hAA);
        run_op("sra_neg", 4'd7, 32'h8000_0000, 32'd4);
        run_op("sll_cf", 4'd5, 32'h4000_0001, 32'd2);
        run_op("srl_cf", 4'd6, 32'h0000_0003, 32'd1);
        run_op("sll_sh0", 4'd5, 32'hFFFF_FFFF, 32'h20);
        run_op("slt_neg", 4'd8, 32'hFFFF_FFFF, 32'd1);
        run_op("sltu_neg", 4'd9, 32'hFFFF_FFFF, 32'd1);
        run_op("op_unused", 4'd12, 32'h1234, 32'h5678);

        // Hold: i_valid=0 keeps prior outputs while inputs change
        run_op("pre_hold", 4'd0, 32'd100, 32'd23);
        @(negedge i_clk);
        i_valid = 1'b0; i_opcode = 4'd1; i_a = 32'd9; i_b = 32'd9;
        @(posedge i_clk); #1;
        check_out("hold", 1'b0);
        @(posedge i_clk); #1;
        check_out("hold2", 1'b0);

        // Asynchronous reset mid-stream, with an operation in flight
        run_op("pre_rst", 4'd1, 32'd3, 32'd5);
        @(negedge i_clk);
        i_valid = 1'b1; i_opcode = 4'd0; i_a = 32'd7; i_b = 32'd8;
        #2 i_rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        @(posedge i_clk); #1;
        check_reset_state("rst_discard");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        run_op("first_after_rst", 4'd0, 32'd7, 32'd8);

        // Randomized stream with occasional idle cycles
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = $urandom; b = a; end
                2: begin a = 32'hFFFF_FFFF - 32'($urandom_range(0, 3)); b = 32'($urandom_range(0, 4)); end
                default: begin a = $urandom; b = 32'($urandom_range(0, 63)); end
            endcase
            if ($urandom_range(0, 7) == 0) begin
                @(negedge i_clk);
                i_valid = 1'b0; i_a = a; i_b = b; i_opcode = op;
                @(posedge i_clk); #1;
                check_out("rnd_idle", 1'b0);
            end else begin
                run_op("rnd", op, a, b);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
